ppd_commutator_ctrl: RTL
========================

Name: ppd_commutator_ctrl

Overview:
- Input-side sequencer for the polyphase decimation (PPD) multiply-add datapath.
- Collects a serial stream of input samples into one parallel frame of gp_decimation_factor samples, in commutator order.
- Hands each frame to the datapath through a one-deep hold register with a valid/ready handshake, and generates the datapath enable pulse.
- Flags overruns and marks when the datapath pipeline has warmed up.

Parameters:
gp_idata_width, 6, input sample width (signed, two's complement)
gp_decimation_factor, 31, samples per frame M; legal range is M>=2
gp_coeff_length, 53, filter length L; used to derive c_col=ceil(L/M)
gp_ccw, 1, commutator direction: 1 = counter clock-wise, 0 = clock-wise

Ports:
i_clk  in  1  rising-edge clock
i_rst  in  1  synchronous active-high reset
i_sync  in  1  phase realign strobe
i_valid  in  1  input sample strobe (no backpressure)
i_data  in  gp_idata_width  input sample, signed
i_frame_ready  in  1  downstream accepts frame
i_clr_ovr  in  1  clear sticky overrun flag
o_frame_valid  out  1  hold register holds an unconsumed frame
o_frame  out  M*gp_idata_width  parallel frame; slot s occupies [(s+1)*W-1 : s*W]
o_ena  out  1  datapath enable = o_frame_valid & i_frame_ready (combinational)
o_phase  out  $clog2(M)  index k of the next sample within the frame
o_overrun  out  1  sticky: a completed frame was dropped
o_out_valid  out  1  one-cycle pulse marking a valid datapath output

Behaviour:
- Reset, i_rst=1 at a clock edge:
  - phase=0, fill buffer=0, hold register=0, o_frame_valid=0, o_overrun=0, warm-up count=0, o_out_valid=0.
  - i_rst overrides all other inputs.
  - A frame in flight mid-operation is lost.
- Sample write:
  - On an edge with i_valid=1, the sample at phase k goes to slot M-1-k when gp_ccw=1, or to slot k when gp_ccw=0.
  - Phase then increments and wraps from M-1 to 0.
- Frame completion (i_valid=1 and phase=M-1):
  - At the same edge, the full fill buffer, including this last sample, is copied to the hold register.
  - o_frame_valid=1 from the next cycle, so latency is 1 cycle from the last-sample edge.
- Handshake:
  - A frame is consumed on an edge where o_frame_valid & i_frame_ready.
  - o_frame is stable while o_frame_valid=1 and not consumed.
  - o_frame_valid drops after consumption unless a new frame completes on that same edge; in that case the new frame is loaded and o_frame_valid stays 1 with no overrun.
- Overrun:
  - Condition: a frame completes while the hold register is occupied and not consumed that edge.
  - The new frame is discarded and the hold register keeps the old frame.
  - o_overrun is set.
  - Phase wraps normally.
- i_clr_ovr clears o_overrun. If overrun and clear occur on the same edge, set wins.
- i_sync:
  - Phase is forced to 0 and the partial fill buffer is discarded (zeroed).
  - If i_valid is on the same edge, that sample is written as k=0 and phase becomes 1.
  - The hold register, o_frame_valid and o_overrun are unaffected.
  - The warm-up count is cleared.
- Fill buffer slots not yet written in the current frame read 0 after reset or i_sync.

Optional Feature:
PPD_CTRL_WARMUP_EN
- Defined:
  - A warm-up counter counts consumed frames and saturates at c_col.
  - o_out_valid pulses 1 cycle after each consumption once the count, including that frame, is >= c_col.
  - The first c_col-1 consumptions after reset or i_sync produce no pulse.
- Undefined: no counter; o_out_valid = o_ena registered by one cycle, i.e. a pulse after every consumption.

Test Plan:
- Order check (M=4, W=6, L=10, gp_ccw=1): feed 1,2,3,4 with i_valid every cycle and i_frame_ready=1 -> o_frame_valid rises 1 cycle after sample 4; o_frame slots[3..0] = 1,2,3,4; o_ena=1 for one cycle.
- Same frame with gp_ccw=0 -> slots[3..0] = 4,3,2,1.
- Backpressure/overrun: i_frame_ready=0, feed 8 samples 1..8 -> hold keeps 1..4, o_overrun=1 after sample 8. Then raise i_clr_ovr together with a new overrun -> o_overrun stays 1. Clear alone -> 0.
- Same-edge consume+complete: i_frame_ready=1 exactly on the sample-8 edge -> frame 5..8 loaded, o_frame_valid stays 1, o_overrun=0.
- i_sync: after 2 samples (a,b), pulse i_sync with i_valid carrying c -> phase=1; next frame c,d,e,f; a and b never appear.
- Warm-up with macro (c_col=3): 5 consumed frames -> o_out_valid pulses after frames 3, 4 and 5 only. Without macro -> pulses after all 5. i_rst mid-frame -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/ppd_commutator_ctrl_if.sv
// Sample-in / frame-out bundle of the PPD input commutator.
// The slave side is the commutator; the master side feeds samples and accepts frames.
interface ppd_commutator_ctrl_if #(
  parameter int gp_idata_width       = 6,
  parameter int gp_decimation_factor = 31
) ();
  logic                                             i_valid;
  logic signed [gp_idata_width-1:0]                 i_data;
  logic                                             i_frame_ready;
  logic                                             o_frame_valid;
  logic [gp_decimation_factor*gp_idata_width-1:0]   o_frame;
  logic                                             o_ena;

  modport slave (
    input  i_valid, i_data, i_frame_ready,
    output o_frame_valid, o_frame, o_ena
  );

  modport master (
    output i_valid, i_data, i_frame_ready,
    input  o_frame_valid, o_frame, o_ena
  );
endinterface

// File: rtl/ppd_commutator_ctrl.sv
// Input commutator for the polyphase decimator: serial samples -> parallel frame,
// one-deep hold register with valid/ready. Optional macro PPD_CTRL_WARMUP_EN gates o_out_valid on pipeline warm-up.
module ppd_commutator_ctrl #(
  parameter int gp_idata_width       = 6,
  parameter int gp_decimation_factor = 31,
  parameter int gp_coeff_length      = 53,
  parameter bit gp_ccw               = 1'b1
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_sync,
  input  logic                                    i_clr_ovr,
  ppd_commutator_ctrl_if.slave                    bus,
  output logic [$clog2(gp_decimation_factor)-1:0] o_phase,
  output logic                                    o_overrun,
  output logic                                    o_out_valid
);

  localparam int W  = gp_idata_width;
  localparam int M  = gp_decimation_factor;
  localparam int PW = $clog2(M);
  localparam int FW = M * W;
  localparam logic [PW-1:0] LAST = PW'(M - 1);

  if (gp_decimation_factor < 2 || gp_coeff_length < 1) begin : g_cfg_err
    $error("ppd_commutator_ctrl: decimation factor must be >= 2 and coefficient length >= 1");
  end

  logic [PW-1:0] phase_q, phase_d, k;
  logic [FW-1:0] fill_q, fill_d, fill_wr;
  logic [FW-1:0] hold_q, hold_d;
  logic          fvld_q, fvld_d;
  logic          ovr_q, ovr_d;
  logic          outv_q, outv_d;
  logic          last, consume, load;

  // Counter-clockwise fills from the top slot down so the oldest sample lands in slot M-1.
  function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] ph);
    return gp_ccw ? (LAST - ph) : ph;
  endfunction

  always_comb begin
    k       = i_sync ? '0 : phase_q;
    consume = fvld_q & bus.i_frame_ready;
    last    = bus.i_valid & (k == LAST);

    fill_wr = i_sync ? '0 : fill_q;
    for (int s = 0; s < M; s++) begin
      if (bus.i_valid && (slot_of(k) == PW'(s))) begin
        fill_wr[s*W +: W] = bus.i_data;
      end
    end

    phase_d = bus.i_valid ? (last ? '0 : k + 1'b1) : k;
    fill_d  = last ? '0 : fill_wr;

    // A completed frame is only taken if the hold slot is free or drains on this edge.
    load    = last & (~fvld_q | consume);
    hold_d  = load ? fill_wr : hold_q;
    fvld_d  = load | (fvld_q & ~consume);
    ovr_d   = (last & fvld_q & ~consume) | (ovr_q & ~i_clr_ovr);
  end

`ifdef PPD_CTRL_WARMUP_EN
  localparam int C_COL = (gp_coeff_length + M - 1) / M;
  localparam int CW    = $clog2(C_COL + 1);
  localparam logic [CW-1:0] CCOL = CW'(C_COL);

  logic [CW-1:0] wcnt_q, wcnt_d, wbase;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CCOL) ? c : c + 1'b1;
  endfunction

  // i_sync restarts warm-up; a consumption on that same edge counts as the first frame.
  always_comb begin
    wbase  = i_sync ? '0 : wcnt_q;
    wcnt_d = consume ? sat_inc(wbase) : wbase;
    outv_d = consume & (sat_inc(wbase) >= CCOL);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`else
  always_comb begin
    outv_d = consume;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      fvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
      outv_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      fvld_q  <= fvld_d;
      ovr_q   <= ovr_d;
      outv_q  <= outv_d;
    end
  end

  assign bus.o_frame_valid = fvld_q;
  assign bus.o_frame       = hold_q;
  assign bus.o_ena         = consume;
  assign o_phase           = phase_q;
  assign o_overrun         = ovr_q;
  assign o_out_valid       = outv_q;

endmodule
